queue_write_arbiter: RTL and testbench

//  Shares the write port of one SyncQueue between NUM_REQ producers (e.g. fetch/LSU/DMA).
//  - Round-robin arbitration, with optional burst locking of the winner for up to MAX_BURST beats.
//  - Zero-latency pass-through: grant, data mux and ready are combinational; only ownership state is registered.
//  - Sits directly in front of the queue wvalid/wready/wdata port and propagates the queue kill.

---
 rtl/rvcpu_arb_pkg.sv | 33 +++
 rtl/rr_priority_pick.sv | 40 ++++
 rtl/queue_write_arbiter.sv | 129 ++++++++++++
 tb/tb_queue_write_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rvcpu_arb_pkg.sv
// Shared arbitration types and helpers for the rvcpu write-port arbiters.
package rvcpu_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    localparam int RR_MAX_REQ = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // First set bit of valid[0:num_req-1], scanning from start and wrapping to 0.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                         input int num_req, input int start);
        rr_pick_t r;
        int       pos;
        r = '0;
        for (int k = num_req - 1; k >= 0; k--) begin
            pos = start + k;
            if (pos >= num_req) pos = pos - num_req;
            if (valid[5'(pos)]) begin
                r.found = 1'b1;
                r.idx   = 5'(pos);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin find-first: rotate the request vector to start at i_start,
// pick the lowest set bit, and map the position back to a requester index.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [SRC_W-1:0]   i_start,
    output logic               o_found,
    output logic [SRC_W-1:0]   o_idx
);

    logic [NUM_REQ-1:0] w_rot;
    int                 w_pos;
    int                 w_first;

    always_comb begin
        w_rot   = '0;
        w_pos   = 0;
        w_first = 0;
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(i_start) + k;
            if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
            w_rot[k] = i_valid[SRC_W'(w_pos)];
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_first = k;
            end
        end
        // Un-rotate; i_start < NUM_REQ so one subtraction keeps the index in range.
        w_pos = int'(i_start) + w_first;
        if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
        o_idx = SRC_W'(w_pos);
    end

endmodule

// File: rtl/queue_write_arbiter.sv
// Round-robin arbiter with burst locking in front of one queue write port.
// Grant, data mux and ready are combinational; only ownership state is registered.
module queue_write_arbiter
    import rvcpu_arb_pkg::*;
#(
    parameter  int DATA_SIZE = 32,
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 4,
    localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         kill,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         q_wvalid,
    output logic [DATA_SIZE-1:0]         q_wdata,
    output logic [SRC_W-1:0]             q_wsrc,
    input  logic                         q_wready,
    output arb_state_t                   o_dbg_state,
    output logic [SRC_W-1:0]             o_dbg_owner,
    output logic [CNT_W-1:0]             o_dbg_cnt,
    output logic [SRC_W-1:0]             o_dbg_rr_ptr
);

    // Handshake: a beat moves when q_wvalid && q_wready; q_wvalid never looks at
    // q_wready, and only the granted requester sees q_wready on its req_ready bit.

    localparam logic [SRC_W-1:0] SRC_ONE = SRC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t       r_st, w_st_nxt;
    logic [SRC_W-1:0] r_owner, w_owner_nxt;
    logic [SRC_W-1:0] r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic             w_owner_hold, w_owner_drop;
    logic [SRC_W-1:0] w_scan_start, w_pick_idx, w_win;
    logic             w_pick_found, w_found, w_active;
    logic [CNT_W-1:0] w_cnt_base;

    function automatic logic [SRC_W-1:0] inc_wrap(input logic [SRC_W-1:0] v);
        if (int'(v) >= NUM_REQ - 1) return '0;
        return v + SRC_ONE;
    endfunction

    assign w_owner_hold = (r_st == ARB_OWNED) &&  req_valid[r_owner];
    assign w_owner_drop = (r_st == ARB_OWNED) && !req_valid[r_owner];
    // A dropped owner releases the lock this cycle; the fresh scan starts just past it.
    assign w_scan_start = w_owner_drop ? inc_wrap(r_owner) : r_rr_ptr;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_pick (
        .i_valid (req_valid),
        .i_start (w_scan_start),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_found    = w_owner_hold || w_pick_found;
    assign w_win      = w_owner_hold ? r_owner : w_pick_idx;
    assign w_cnt_base = w_owner_hold ? r_cnt : '0;
    assign w_active   = rst_n && !kill && w_found;

    assign q_wvalid = w_active;
    assign q_wsrc   = w_active ? w_win : '0;

    always_comb begin
        q_wdata   = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_active && (w_win == SRC_W'(i))) begin
                q_wdata      = req_data[i*DATA_SIZE +: DATA_SIZE];
                req_ready[i] = q_wready;
            end
        end
    end

    always_comb begin
        w_st_nxt    = r_st;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = w_owner_drop ? inc_wrap(r_owner) : r_rr_ptr;
        if (kill) begin
            w_st_nxt  = ARB_IDLE;
            w_cnt_nxt = '0;
            w_rr_nxt  = r_rr_ptr;
        end else if (!w_found) begin
            w_st_nxt  = ARB_IDLE;
            w_cnt_nxt = '0;
        end else if (!q_wready) begin
            w_st_nxt    = ARB_OWNED;
            w_owner_nxt = w_win;
            w_cnt_nxt   = w_cnt_base;
        end else if (int'(w_cnt_base) + 1 < MAX_BURST) begin
            w_st_nxt    = ARB_OWNED;
            w_owner_nxt = w_win;
            w_cnt_nxt   = w_cnt_base + CNT_ONE;
        end else begin
            w_st_nxt  = ARB_IDLE;
            w_cnt_nxt = '0;
            w_rr_nxt  = inc_wrap(w_win);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st     <= ARB_IDLE;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_st     <= w_st_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    assign o_dbg_state  = r_st;
    assign o_dbg_owner  = r_owner;
    assign o_dbg_cnt    = r_cnt;
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_queue_write_arbiter.sv
// Directed bench: arbiter in front of a 3-entry queue model, one task per scenario.
module tb_queue_write_arbiter;
    import rvcpu_arb_pkg::*;

    localparam int DATA_SIZE = 32;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;
    localparam int Q_DEPTH   = 3;

    logic                         clk;
    logic                         rst_n;
    logic                         kill;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         q_wvalid;
    logic [DATA_SIZE-1:0]         q_wdata;
    logic [1:0]                   q_wsrc;
    logic                         q_wready;
    arb_state_t                   dbg_state;
    logic [1:0]                   dbg_owner;
    logic [2:0]                   dbg_cnt;
    logic [1:0]                   dbg_rr_ptr;

    logic pop_en;
    int   q_count;
    int   n_cmp;
    int   n_bad;
    logic [1:0] exp_q[$];

    queue_write_arbiter #(
        .DATA_SIZE (DATA_SIZE),
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kill         (kill),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .q_wvalid     (q_wvalid),
        .q_wdata      (q_wdata),
        .q_wsrc       (q_wsrc),
        .q_wready     (q_wready),
        .o_dbg_state  (dbg_state),
        .o_dbg_owner  (dbg_owner),
        .o_dbg_cnt    (dbg_cnt),
        .o_dbg_rr_ptr (dbg_rr_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // queue model: occupancy only, flushed by kill
    assign q_wready = (q_count < Q_DEPTH);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_count <= 0;
        else if (kill) q_count <= 0;
        else q_count <= q_count + ((q_wvalid && q_wready) ? 1 : 0)
                                - ((pop_en && q_count > 0) ? 1 : 0);
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; kill = 1'b0; pop_en = 1'b0; req_valid = '0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; kill = 1'b0; pop_en = 1'b0; req_valid = 4'hF;
        step(); #1;
        n_cmp++; if (q_wvalid !== 1'b0) begin n_bad++; $display("FAIL reset_wvalid: got %b want 0", q_wvalid); end
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_ready: got %h want 0", req_ready); end
        n_cmp++; if (q_wsrc !== 2'd0) begin n_bad++; $display("FAIL reset_wsrc: got %0d want 0", q_wsrc); end
        n_cmp++; if (q_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", q_wdata); end
        n_cmp++; if (dbg_state !== ARB_IDLE || dbg_cnt !== 3'd0 || dbg_rr_ptr !== 2'd0 || dbg_owner !== 2'd0) begin
            n_bad++; $display("FAIL reset_regs: got st=%0d cnt=%0d rr=%0d own=%0d want 0/0/0/0",
                              dbg_state, dbg_cnt, dbg_rr_ptr, dbg_owner);
        end
        step();
        rst_n = 1'b1; #1;
        n_cmp++; if (q_wvalid !== 1'b1) begin n_bad++; $display("FAIL release_wvalid: got %b want 1", q_wvalid); end
        n_cmp++; if (q_wsrc !== 2'd0) begin n_bad++; $display("FAIL release_wsrc: got %0d want 0", q_wsrc); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL release_ready: got %b want 0001", req_ready); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_src;
        int         beat;
        do_reset();
        req_valid = 4'hF; pop_en = 1'b1;
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                  2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        beat = 0;
        while (exp_q.size() > 0) begin
            exp_src = exp_q.pop_front();
            #1;
            n_cmp++; if (q_wsrc !== exp_src) begin n_bad++; $display("FAIL rr_src[%0d]: got %0d want %0d", beat, q_wsrc, exp_src); end
            n_cmp++; if (req_ready !== (4'b0001 << exp_src)) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", beat, req_ready, 4'b0001 << exp_src); end
            n_cmp++; if (q_wdata !== (32'hA5A5_0000 | 32'(exp_src))) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", beat, q_wdata, 32'hA5A5_0000 | 32'(exp_src)); end
            step();
            beat++;
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        req_valid = 4'b0100; pop_en = 1'b1;
        for (int k = 0; k < MAX_BURST; k++) begin
            #1;
            n_cmp++; if (q_wsrc !== 2'd2 || q_wdata !== 32'hA5A5_0002) begin n_bad++; $display("FAIL single_beat[%0d]: got src=%0d data=%h want 2/a5a50002", k, q_wsrc, q_wdata); end
            n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready[%0d]: got %b want 0100", k, req_ready); end
            n_cmp++; if (dbg_cnt !== 3'(k)) begin n_bad++; $display("FAIL single_cnt[%0d]: got %0d want %0d", k, dbg_cnt, k); end
            step();
        end
        #1;
        n_cmp++; if (dbg_rr_ptr !== 2'd3) begin n_bad++; $display("FAIL single_rr: got %0d want 3", dbg_rr_ptr); end
        n_cmp++; if (dbg_state !== ARB_IDLE) begin n_bad++; $display("FAIL single_state: got %0d want IDLE", dbg_state); end
        n_cmp++; if (q_wvalid !== 1'b1 || q_wsrc !== 2'd2) begin n_bad++; $display("FAIL single_rewin: got v=%b src=%0d want 1/2", q_wvalid, q_wsrc); end
        step();
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b0001; pop_en = 1'b0;
        step(); step();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (q_wvalid !== 1'b1 || q_wsrc !== 2'd1 || q_wdata !== 32'hA5A5_0001) begin
                n_bad++; $display("FAIL stall_grant[%0d]: got v=%b src=%0d data=%h want 1/1/a5a50001", k, q_wvalid, q_wsrc, q_wdata);
            end
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", k, req_ready); end
            n_cmp++; if (dbg_state !== ARB_OWNED || dbg_owner !== 2'd1 || dbg_cnt !== 3'd1) begin
                n_bad++; $display("FAIL stall_regs[%0d]: got st=%0d own=%0d cnt=%0d want OWNED/1/1", k, dbg_state, dbg_owner, dbg_cnt);
            end
            step();
        end
        pop_en = 1'b1;
        step();
        pop_en = 1'b0; #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL drain_ready: got %b want 0010", req_ready); end
        step(); #1;
        n_cmp++; if (dbg_cnt !== 3'd2 || dbg_owner !== 2'd1) begin n_bad++; $display("FAIL drain_cnt: got cnt=%0d own=%0d want 2/1", dbg_cnt, dbg_owner); end
        n_cmp++; if (dbg_rr_ptr !== 2'd1) begin n_bad++; $display("FAIL drain_rr: got %0d want 1", dbg_rr_ptr); end
        step();
    endtask

    task automatic test_owner_drop();
        do_reset();
        req_valid = 4'b0001; pop_en = 1'b1;
        step(); step();
        #1;
        n_cmp++; if (dbg_owner !== 2'd0 || dbg_cnt !== 3'd2) begin n_bad++; $display("FAIL drop_pre: got own=%0d cnt=%0d want 0/2", dbg_owner, dbg_cnt); end
        req_valid = 4'b1000; #1;
        n_cmp++; if (q_wvalid !== 1'b1 || q_wsrc !== 2'd3) begin n_bad++; $display("FAIL drop_switch: got v=%b src=%0d want 1/3", q_wvalid, q_wsrc); end
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL drop_ready: got %b want 1000", req_ready); end
        step(); #1;
        n_cmp++; if (dbg_rr_ptr !== 2'd1) begin n_bad++; $display("FAIL drop_rr: got %0d want 1", dbg_rr_ptr); end
        n_cmp++; if (dbg_owner !== 2'd3 || dbg_cnt !== 3'd1) begin n_bad++; $display("FAIL drop_newown: got own=%0d cnt=%0d want 3/1", dbg_owner, dbg_cnt); end
        step();
    endtask

    task automatic test_kill();
        do_reset();
        req_valid = 4'b0010; pop_en = 1'b1;
        step(); step();
        kill = 1'b1; #1;
        n_cmp++; if (q_wvalid !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL kill_gate: got v=%b ready=%b want 0/0000", q_wvalid, req_ready); end
        n_cmp++; if (q_wsrc !== 2'd0) begin n_bad++; $display("FAIL kill_wsrc: got %0d want 0", q_wsrc); end
        step();
        kill = 1'b0; #1;
        n_cmp++; if (dbg_state !== ARB_IDLE || dbg_cnt !== 3'd0 || dbg_rr_ptr !== 2'd0) begin
            n_bad++; $display("FAIL kill_regs: got st=%0d cnt=%0d rr=%0d want IDLE/0/0", dbg_state, dbg_cnt, dbg_rr_ptr);
        end
        n_cmp++; if (q_wvalid !== 1'b1 || q_wsrc !== 2'd1) begin n_bad++; $display("FAIL kill_rewin: got v=%b src=%0d want 1/1", q_wvalid, q_wsrc); end
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'hF; pop_en = 1'b1;
        step(); step();
        #2;
        rst_n = 1'b0; #1;
        n_cmp++; if (dbg_state !== ARB_IDLE || dbg_cnt !== 3'd0) begin n_bad++; $display("FAIL async_regs: got st=%0d cnt=%0d want IDLE/0", dbg_state, dbg_cnt); end
        n_cmp++; if (q_wvalid !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL async_out: got v=%b ready=%b want 0/0000", q_wvalid, req_ready); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; kill = 1'b0; pop_en = 1'b0; req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_SIZE +: DATA_SIZE] = 32'hA5A5_0000 | 32'(i);
        test_reset();
        test_round_robin();
        test_single_requester();
        test_stall();
        test_owner_drop();
        test_kill();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
